// File: rtl/tt_sweep_capture.sv
// -----------------------------------------------------------------------------
// tt_sweep_capture
//
// Purpose:
//   Sweeps all 128 input vectors of an external 7-input combinational function,
//   holds each vector for SETTLE_CYCLES clocks, samples the function output at
//   the end of each hold and assembles the 128-bit truth table. The captured
//   table is compared against a golden table supplied on 'expected'.
//
// Optional feature:
//   TT_SWEEP_ONES_COUNT_EN - when defined, adds the ones_count output, which
//   reports how many vectors produced f_in=1 during the last sweep.
//
// Ports:
//   clk        in   1    sole clock, rising edge
//   rst_n      in   1    asynchronous active-low reset
//   start      in   1    sweep request, accepted only while idle
//   abort      in   1    cancels a sweep that is driving vectors
//   expected   in   128  golden truth table
//   f_in       in   1    output of the function under test
//   x          out  7    vector applied to the function (x[0] -> input x0)
//   busy       out  1    vectors are being driven
//   done       out  1    one-cycle pulse when a sweep completes
//   tt         out  128  captured table, tt[i] = f(x=i)
//   tt_valid   out  1    tt holds a complete sweep
//   match      out  1    tt_valid and tt == expected
//   ones_count out  8    count of ones in the sweep (feature builds only)
//
// Parameter:
//   SETTLE_CYCLES  cycles each vector is held before sampling, 1..15
// -----------------------------------------------------------------------------
module tt_sweep_capture #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [127:0] expected,
  input  logic         f_in,
  output logic [6:0]   x,
  output logic         busy,
  output logic         done,
  output logic [127:0] tt,
  output logic         tt_valid,
  output logic         match
`ifdef TT_SWEEP_ONES_COUNT_EN
  ,
  output logic [7:0]   ones_count
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Value of the settle counter in the last hold cycle of a vector.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t       state_q, state_d;
  logic [6:0]   x_q, x_d;
  logic [3:0]   settle_q, settle_d;
  logic [127:0] tt_q, tt_d;
  logic         tt_valid_q, tt_valid_d;
`ifdef TT_SWEEP_ONES_COUNT_EN
  logic [7:0]   ones_q, ones_d;
`endif

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    settle_d   = settle_q;
    tt_d       = tt_q;
    tt_valid_d = tt_valid_q;
`ifdef TT_SWEEP_ONES_COUNT_EN
    ones_d     = ones_q;
`endif
    case (state_q)
      IDLE: begin
        // abort has no effect here, so start always wins.
        if (start) begin
          state_d    = DRIVE;
          x_d        = 7'd0;
          settle_d   = 4'd0;
          tt_valid_d = 1'b0;
`ifdef TT_SWEEP_ONES_COUNT_EN
          ones_d     = 8'd0;
`endif
        end
      end
      DRIVE: begin
        if (abort) begin
          // Abort beats the sample due on this edge; tt_valid is already 0.
          state_d  = IDLE;
          x_d      = 7'd0;
          settle_d = 4'd0;
        end else if (settle_q == SETTLE_LAST) begin
          tt_d[x_q] = f_in;
          settle_d  = 4'd0;
`ifdef TT_SWEEP_ONES_COUNT_EN
          ones_d    = ones_q + {7'd0, f_in};
`endif
          if (x_q == 7'd127) begin
            // x stays at 127 through the FINISH cycle.
            state_d    = FINISH;
            tt_valid_d = 1'b1;
          end else begin
            x_d = x_q + 7'd1;
          end
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      FINISH: begin
        state_d = IDLE;
        x_d     = 7'd0;
      end
      default: begin
        state_d = IDLE;
        x_d     = 7'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      x_q        <= 7'd0;
      settle_q   <= 4'd0;
      tt_q       <= '0;
      tt_valid_q <= 1'b0;
`ifdef TT_SWEEP_ONES_COUNT_EN
      ones_q     <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      settle_q   <= settle_d;
      tt_q       <= tt_d;
      tt_valid_q <= tt_valid_d;
`ifdef TT_SWEEP_ONES_COUNT_EN
      ones_q     <= ones_d;
`endif
    end
  end

  assign x        = x_q;
  assign busy     = (state_q == DRIVE);
  assign done     = (state_q == FINISH);
  assign tt       = tt_q;
  assign tt_valid = tt_valid_q;
  // Combinational on expected so a changed golden table is reflected at once.
  assign match    = tt_valid_q && (tt_q == expected);
`ifdef TT_SWEEP_ONES_COUNT_EN
  assign ones_count = ones_q;
`endif

endmodule

// File: tb/tb_tt_sweep_capture.sv
// -----------------------------------------------------------------------------
// tb_tt_sweep_capture
//
// Two instances (SETTLE_CYCLES = 1 and 3) share clock, reset and control
// inputs; each sees its own function output computed from its own x. A
// sweep-level model (elapsed cycles since an accepted start) predicts every
// output and is compared on each falling edge; literal expectations pin the
// model on known truth tables and sweep lengths.
// -----------------------------------------------------------------------------
module tb_tt_sweep_capture;

  localparam int S0 = 1;
  localparam int S1 = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [127:0] expected = '0;
  logic [1:0]   fsel = 2'd0;   // 0: x0, 1: x6, 2: maj(x0,x1,x6), 3: const 0

  logic [6:0]   x_o [2];
  logic         busy_o [2];
  logic         done_o [2];
  logic [127:0] tt_o [2];
  logic         tt_valid_o [2];
  logic         match_o [2];
  logic         f_in_w [2];
`ifdef TT_SWEEP_ONES_COUNT_EN
  logic [7:0]   ones_o [2];
`endif

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  function automatic logic fmod(input logic [1:0] sel, input logic [6:0] v);
    case (sel)
      2'd0:    return v[0];
      2'd1:    return v[6];
      2'd2:    return (v[0] & v[1]) | (v[0] & v[6]) | (v[1] & v[6]);
      default: return 1'b0;
    endcase
  endfunction

  function automatic int sof(input int k);
    return (k == 0) ? S0 : S1;
  endfunction

  assign f_in_w[0] = fmod(fsel, x_o[0]);
  assign f_in_w[1] = fmod(fsel, x_o[1]);

  tt_sweep_capture #(.SETTLE_CYCLES(S0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .expected(expected), .f_in(f_in_w[0]), .x(x_o[0]), .busy(busy_o[0]),
    .done(done_o[0]), .tt(tt_o[0]), .tt_valid(tt_valid_o[0]),
    .match(match_o[0])
`ifdef TT_SWEEP_ONES_COUNT_EN
    , .ones_count(ones_o[0])
`endif
  );

  tt_sweep_capture #(.SETTLE_CYCLES(S1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .expected(expected), .f_in(f_in_w[1]), .x(x_o[1]), .busy(busy_o[1]),
    .done(done_o[1]), .tt(tt_o[1]), .tt_valid(tt_valid_o[1]),
    .match(match_o[1])
`ifdef TT_SWEEP_ONES_COUNT_EN
    , .ones_count(ones_o[1])
`endif
  );

  // ---------------- model: sweep described by elapsed cycles ---------------
  logic         m_act [2];
  int           m_e [2];
  logic         m_valid [2];
  logic [127:0] m_tt [2];
  int           m_ones [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_act[k]   <= 1'b0;
        m_e[k]     <= 0;
        m_valid[k] <= 1'b0;
        m_tt[k]    <= '0;
        m_ones[k]  <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int s;
        s = sof(k);
        if (m_act[k]) begin
          if (m_e[k] < 128 * s) begin
            if (abort) begin
              m_act[k] <= 1'b0;
              m_e[k]   <= 0;
            end else begin
              if ((m_e[k] % s) == s - 1) begin
                m_tt[k][m_e[k] / s] <= fmod(fsel, 7'(m_e[k] / s));
                m_ones[k] <= m_ones[k] + int'(fmod(fsel, 7'(m_e[k] / s)));
              end
              if (m_e[k] == 128 * s - 1) m_valid[k] <= 1'b1;
              m_e[k] <= m_e[k] + 1;
            end
          end else begin
            m_act[k] <= 1'b0;
            m_e[k]   <= 0;
          end
        end else if (start) begin
          m_act[k]   <= 1'b1;
          m_e[k]     <= 0;
          m_valid[k] <= 1'b0;
          m_ones[k]  <= 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    for (int k = 0; k < 2; k++) begin
      int s;
      logic mb, md;
      int mx;
      s  = sof(k);
      mb = m_act[k] && (m_e[k] < 128 * s);
      md = m_act[k] && (m_e[k] == 128 * s);
      mx = mb ? m_e[k] / s : (md ? 127 : 0);
      chk($sformatf("busy%0d", k), 128'(busy_o[k]), 128'(mb));
      chk($sformatf("done%0d", k), 128'(done_o[k]), 128'(md));
      chk($sformatf("x%0d", k), 128'(x_o[k]), 128'(mx));
      chk($sformatf("tt_valid%0d", k), 128'(tt_valid_o[k]), 128'(m_valid[k]));
      chk($sformatf("tt%0d", k), tt_o[k], m_tt[k]);
      chk($sformatf("match%0d", k), 128'(match_o[k]),
          128'(m_valid[k] && (m_tt[k] == expected)));
`ifdef TT_SWEEP_ONES_COUNT_EN
      chk($sformatf("ones%0d", k), 128'(ones_o[k]), 128'(m_ones[k]));
`endif
    end
  endtask

  // Runs one sweep from an idle state and reports the cycle (1 = cycle after
  // the start edge) in which each instance showed done, 0 if never.
  task automatic run_sweep(input int repulse, input int abort_at, input bit both,
                           input bit abort_fin, output int d0, output int d1);
    int n;
    @(negedge clk);
    start = 1'b1;
    abort = both;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    n = 1; d0 = 0; d1 = 0;
    while (1) begin
      if (done_o[0] && d0 == 0) d0 = n;
      if (done_o[1] && d1 == 0) d1 = n;
      if (!busy_o[0] && !busy_o[1]) break;
      if (n >= 1000) begin
        n_chk++; n_err++;
        $display("FAIL sweep_timeout actual=%0d cycles required=<1000", n);
        break;
      end
      start = (repulse >= 0) && busy_o[0] && (x_o[0] == 7'(repulse));
      abort = ((abort_at >= 0) && busy_o[0] && (x_o[0] == 7'(abort_at))) ||
              (abort_fin && done_o[0]);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    int d0, d1, n;
    logic [127:0] e6;
    fork
      forever begin
        @(negedge clk);
        cmp_all();
      end
    join_none

    // Reset state.
    #1;
    chk("rst_busy", 128'(busy_o[0]), 128'(0));
    chk("rst_tt_valid", 128'(tt_valid_o[1]), 128'(0));
    @(negedge clk);
    #2 rst_n = 1'b1;

    // f = x0.
    fsel = 2'd0;
    run_sweep(-1, -1, 1'b0, 1'b0, d0, d1);
    chk("x0_done0_cycle", 128'(d0), 128'(129));
    chk("x0_done1_cycle", 128'(d1), 128'(385));
    chk("x0_tt0", tt_o[0], 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA);
    chk("x0_tt1", tt_o[1], 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA);
`ifdef TT_SWEEP_ONES_COUNT_EN
    chk("x0_ones0", 128'(ones_o[0]), 128'(64));
`endif

    // f = x6 with matching golden table.
    fsel = 2'd1;
    e6 = 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000;
    expected = e6;
    run_sweep(-1, -1, 1'b0, 1'b0, d0, d1);
    chk("x6_done1_cycle", 128'(d1), 128'(385));
    @(negedge clk);
    chk("x6_match1", 128'(match_o[1]), 128'(1));
    expected = e6 ^ (128'(1) << 5);
    #1;
    chk("x6_mismatch1", 128'(match_o[1]), 128'(0));

    // Majority of x0, x1, x6.
    fsel = 2'd2;
    run_sweep(-1, -1, 1'b0, 1'b0, d0, d1);
    chk("maj_tt0", tt_o[0], 128'hEEEE_EEEE_EEEE_EEEE_8888_8888_8888_8888);
    chk("maj_tt1", tt_o[1], 128'hEEEE_EEEE_EEEE_EEEE_8888_8888_8888_8888);
`ifdef TT_SWEEP_ONES_COUNT_EN
    chk("maj_ones1", 128'(ones_o[1]), 128'(64));
`endif

    // Abort at x=40, then a full sweep.
    fsel = 2'd0;
    run_sweep(-1, 40, 1'b0, 1'b0, d0, d1);
    chk("abort_no_done", 128'(d0), 128'(0));
    chk("abort_busy0", 128'(busy_o[0]), 128'(0));
    chk("abort_x0", 128'(x_o[0]), 128'(0));
    chk("abort_tt_valid0", 128'(tt_valid_o[0]), 128'(0));
    chk("abort_match0", 128'(match_o[0]), 128'(0));
    run_sweep(-1, -1, 1'b0, 1'b0, d0, d1);
    chk("post_abort_done0", 128'(d0), 128'(129));

    // Start re-pulsed mid-sweep is ignored.
    run_sweep(10, -1, 1'b0, 1'b0, d0, d1);
    chk("repulse_done0", 128'(d0), 128'(129));
    chk("repulse_done1", 128'(d1), 128'(385));

    // Start and abort together while idle: start wins.
    run_sweep(-1, -1, 1'b1, 1'b0, d0, d1);
    chk("start_wins_done0", 128'(d0), 128'(129));

    // Abort during FINISH of instance 0 is ignored there.
    run_sweep(-1, -1, 1'b0, 1'b1, d0, d1);
    chk("fin_abort_done0", 128'(d0), 128'(129));
    chk("fin_abort_valid0", 128'(tt_valid_o[0]), 128'(1));

    // Constant 0 against a zero golden table.
    fsel = 2'd3;
    expected = '0;
    run_sweep(-1, -1, 1'b0, 1'b0, d0, d1);
    chk("zero_match0", 128'(match_o[0]), 128'(1));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero_match_after_start", 128'(match_o[0]), 128'(0));
    n = 0;
    while ((busy_o[0] || busy_o[1] || done_o[1]) && n < 1000) begin
      @(negedge clk);
      n++;
    end

    // Asynchronous reset at x=90.
    fsel = 2'd0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(busy_o[0] && x_o[0] == 7'd90) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_x90", 128'(x_o[0]), 128'(90));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy0", 128'(busy_o[0]), 128'(0));
    chk("arst_x0", 128'(x_o[0]), 128'(0));
    chk("arst_x1", 128'(x_o[1]), 128'(0));
    chk("arst_tt0", tt_o[0], 128'(0));
    chk("arst_done0", 128'(done_o[0]), 128'(0));
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_restart_busy0", 128'(busy_o[0]), 128'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
